fabric_config_loader: RTL



---
 rtl/fabric_config_loader.sv | 93 +++++++++
 1 files changed

// File: rtl/fabric_config_loader.sv
// fabric_config_loader: streams configuration words into the fabric register
// bus, accumulates an XOR checksum, and holds the fabric in clear until a
// complete image with a matching checksum has been accepted.
module fabric_config_loader #(
  parameter int WORD_W    = 33,
  parameter int NUM_WORDS = 14,
  parameter int ADDR_W    = 4
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              cfg_we,
  output logic [ADDR_W-1:0] cfg_addr,
  output logic [WORD_W-1:0] cfg_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              fabric_clear
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] cnt;
  logic [WORD_W-1:0] acc;
  logic              hs;

  // All status outputs decode directly from state, so an async clear
  // forces them to their idle values in the same instant.
  assign in_ready     = (state == S_LOAD) || (state == S_CHECK);
  assign busy         = in_ready;
  assign done         = (state == S_DONE);
  assign error        = (state == S_ERR);
  assign fabric_clear = ~done;
  assign hs           = in_valid & in_ready;

  // Write bus: one registered strobe per accepted config word; the
  // checksum word is never forwarded to the fabric.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      cfg_we   <= 1'b0;
      cfg_addr <= '0;
      cfg_data <= '0;
    end else begin
      cfg_we <= hs && (state == S_LOAD);
      if (hs && (state == S_LOAD)) begin
        cfg_addr <= cnt;
        cfg_data <= in_data;
      end
    end
  end

  // Control FSM with word counter and checksum accumulator. start is only
  // honoured outside LOAD/CHECK, so a stray pulse cannot disturb a load.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= S_IDLE;
      cnt   <= '0;
      acc   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state <= S_LOAD;
            cnt   <= '0;
            acc   <= '0;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            acc <= acc ^ in_data;
            if (cnt == LAST_IDX) state <= S_CHECK;
            else                 cnt   <= cnt + 1'b1;
          end
        end
        S_CHECK: begin
          if (in_valid) state <= (in_data == acc) ? S_DONE : S_ERR;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
